// File: rtl/ro_sched_pkg.sv
// Shared types and helpers for the ring-oscillator scan scheduler.
package ro_sched_pkg;

  localparam int SCAN_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_GATE,
    ST_HOLD,
    ST_STORE,
    ST_NEXT
  } state_t;

  // Select width never drops below one bit so a 2-RO bank still has a real mux select.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ro_next_sel.sv
// Finds the lowest set mask bit strictly above i_idx; with i_wrap set it falls
// back to the lowest set bit overall. o_vld is low when nothing qualifies.
module ro_next_sel
  import ro_sched_pkg::*;
#(
  parameter int  NUM_RO = 16,
  localparam int SEL_W  = sel_w(NUM_RO)
) (
  input  logic [NUM_RO-1:0] i_mask,
  input  logic [SEL_W-1:0]  i_idx,
  input  logic              i_wrap,
  output logic              o_vld,
  output logic [SEL_W-1:0]  o_idx
);

  logic             w_above_vld;
  logic             w_low_vld;
  logic [SEL_W-1:0] w_above_idx;
  logic [SEL_W-1:0] w_low_idx;

  // Scanning downward lets the last hit be the lowest qualifying index.
  always_comb begin
    w_above_vld = 1'b0;
    w_above_idx = '0;
    w_low_vld   = 1'b0;
    w_low_idx   = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_low_vld = 1'b1;
        w_low_idx = SEL_W'(i);
        if (i > int'(i_idx)) begin
          w_above_vld = 1'b1;
          w_above_idx = SEL_W'(i);
        end
      end
    end
  end

  assign o_vld = w_above_vld | (i_wrap & w_low_vld);
  assign o_idx = w_above_vld ? w_above_idx : w_low_idx;

endmodule

// File: rtl/ro_scan_scheduler.sv
// Walks each enabled ring oscillator through the shared edge counter:
// clear/settle, gate, drain, store; single-pass or continuous, abortable.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | RO selected, counter held in clear for the settle time
// GATE   | ro_en high for the programmed window
// HOLD   | ro_en low while the count drains through the CDC freeze
// STORE  | result written to slot ro_sel
// NEXT   | advance to the next enabled RO, or end the pass
module ro_scan_scheduler
  import ro_sched_pkg::*;
#(
  parameter int  NUM_RO    = 16,
  parameter int  WIN_W     = 24,
  parameter int  SETTLE_W  = 8,
  parameter int  CNT_W     = 32,
  parameter int  DRAIN_CYC = 4,
  localparam int SEL_W     = sel_w(NUM_RO)
) (
  input  logic                  i_aclk,
  input  logic                  i_aresetn,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [NUM_RO-1:0]     i_cfg_mask,
  input  logic [WIN_W-1:0]      i_cfg_window,
  input  logic [SETTLE_W-1:0]   i_cfg_settle,
  input  logic                  i_cfg_continuous,
  input  logic [CNT_W-1:0]      i_cnt_value,
  output logic [SEL_W-1:0]      o_ro_sel,
  output logic                  o_ro_en,
  output logic                  o_cnt_clr,
  output logic                  o_res_we,
  output logic [SEL_W-1:0]      o_res_addr,
  output logic [CNT_W-1:0]      o_res_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [SCAN_CNT_W-1:0] o_scan_cnt
);

  localparam int PH_W = (WIN_W > SETTLE_W) ? WIN_W : SETTLE_W;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PH_W-1:0]       r_phase;
  logic [PH_W-1:0]       w_phase_nxt;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_sel_nxt;
  logic                  w_shadow_ld;
  logic                  w_done_nxt;

  logic [NUM_RO-1:0]     r_mask;
  logic [WIN_W-1:0]      r_window;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_cont;

  logic                  r_ro_en;
  logic                  r_cnt_clr;
  logic                  r_res_we;
  logic [SEL_W-1:0]      r_res_addr;
  logic [CNT_W-1:0]      r_res_data;
  logic                  r_busy;
  logic                  r_done;
  logic [SCAN_CNT_W-1:0] r_scan_cnt;

  logic                  w_shadow_vld;
  logic [SEL_W-1:0]      w_shadow_idx;
  logic                  w_live_vld;
  logic [SEL_W-1:0]      w_live_idx;

  // Next RO inside the current pass comes from the shadowed mask.
  ro_next_sel #(.NUM_RO(NUM_RO)) u_sel_shadow (
    .i_mask (r_mask),
    .i_idx  (r_sel),
    .i_wrap (1'b0),
    .o_vld  (w_shadow_vld),
    .o_idx  (w_shadow_idx)
  );

  // First RO of a new pass comes from the live mask, which is shadowed on that same edge.
  ro_next_sel #(.NUM_RO(NUM_RO)) u_sel_live (
    .i_mask (i_cfg_mask),
    .i_idx  (SEL_W'(NUM_RO - 1)),
    .i_wrap (1'b1),
    .o_vld  (w_live_vld),
    .o_idx  (w_live_idx)
  );

  // Down-counter load value for a phase of max(len,1) cycles.
  function automatic logic [PH_W-1:0] len_m1(input logic [PH_W-1:0] len);
    return (len == '0) ? '0 : len - PH_W'(1);
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_sel_nxt   = r_sel;
    w_shadow_ld = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !i_abort) begin
          w_shadow_ld = 1'b1;
          if (w_live_vld) begin
            w_state_nxt = ST_SELECT;
            w_sel_nxt   = w_live_idx;
            w_phase_nxt = len_m1(PH_W'(i_cfg_settle));
          end else begin
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_SELECT: begin
        if (r_phase == '0) begin
          w_state_nxt = ST_GATE;
          w_phase_nxt = len_m1(PH_W'(r_window));
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      ST_GATE: begin
        if (r_phase == '0) begin
          w_state_nxt = ST_HOLD;
          w_phase_nxt = PH_W'(DRAIN_CYC - 1);
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_phase == '0) begin
          w_state_nxt = ST_STORE;
        end else begin
          w_phase_nxt = r_phase - PH_W'(1);
        end
      end
      ST_STORE: begin
        w_state_nxt = ST_NEXT;
        w_done_nxt  = !w_shadow_vld;
      end
      ST_NEXT: begin
        if (w_shadow_vld) begin
          w_state_nxt = ST_SELECT;
          w_sel_nxt   = w_shadow_idx;
          w_phase_nxt = len_m1(PH_W'(r_settle));
        end else if (r_cont) begin
          w_shadow_ld = 1'b1;
          if (w_live_vld) begin
            w_state_nxt = ST_SELECT;
            w_sel_nxt   = w_live_idx;
            w_phase_nxt = len_m1(PH_W'(i_cfg_settle));
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything decided above, including a pending done or restart.
    if (i_abort && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_sel_nxt   = r_sel;
      w_shadow_ld = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_sel      <= '0;
      r_mask     <= '0;
      r_window   <= '0;
      r_settle   <= '0;
      r_cont     <= 1'b0;
      r_ro_en    <= 1'b0;
      r_cnt_clr  <= 1'b0;
      r_res_we   <= 1'b0;
      r_res_addr <= '0;
      r_res_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_scan_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_sel   <= w_sel_nxt;
      if (w_shadow_ld) begin
        r_mask   <= i_cfg_mask;
        r_window <= i_cfg_window;
        r_settle <= i_cfg_settle;
        r_cont   <= i_cfg_continuous;
      end
      // Outputs decode the next state so they change cleanly on the state edge.
      r_ro_en   <= (w_state_nxt == ST_GATE);
      r_cnt_clr <= (w_state_nxt == ST_SELECT);
      r_res_we  <= (w_state_nxt == ST_STORE);
      if (w_state_nxt == ST_STORE) begin
        r_res_addr <= r_sel;
        r_res_data <= i_cnt_value;
      end
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_nxt;
      if (w_done_nxt) begin
        r_scan_cnt <= r_scan_cnt + SCAN_CNT_W'(1);
      end
    end
  end

  assign o_ro_sel   = r_sel;
  assign o_ro_en    = r_ro_en;
  assign o_cnt_clr  = r_cnt_clr;
  assign o_res_we   = r_res_we;
  assign o_res_addr = r_res_addr;
  assign o_res_data = r_res_data;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_scan_cnt = r_scan_cnt;

endmodule

// File: tb/tb_ro_scan_scheduler.sv
// Bench for ro_scan_scheduler: a per-pass timeline model checked every cycle,
// directed scenarios with hand-computed cycle numbers, then random traffic.
module tb_ro_scan_scheduler;

  localparam int NUM_RO = 4;
  localparam int DRAIN  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, cfg_cont;
  logic [3:0]  cfg_mask;
  logic [23:0] cfg_window;
  logic [7:0]  cfg_settle;
  logic [31:0] cnt_value;
  logic [1:0]  ro_sel, res_addr;
  logic        ro_en, cnt_clr, res_we, busy, done;
  logic [31:0] res_data;
  logic [15:0] scan_cnt;

  int n_total = 0;
  int n_bad   = 0;

  ro_scan_scheduler #(
    .NUM_RO(NUM_RO), .WIN_W(24), .SETTLE_W(8), .CNT_W(32), .DRAIN_CYC(DRAIN)
  ) dut (
    .i_aclk(clk), .i_aresetn(rst_n), .i_start(start), .i_abort(abort),
    .i_cfg_mask(cfg_mask), .i_cfg_window(cfg_window), .i_cfg_settle(cfg_settle),
    .i_cfg_continuous(cfg_cont), .i_cnt_value(cnt_value),
    .o_ro_sel(ro_sel), .o_ro_en(ro_en), .o_cnt_clr(cnt_clr), .o_res_we(res_we),
    .o_res_addr(res_addr), .o_res_data(res_data), .o_busy(busy), .o_done(done),
    .o_scan_cnt(scan_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one record per expected busy cycle ----------------
  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       clr;
    logic       we;
    logic       last;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  bit          cur_v = 0;
  bit          sh_cont = 0;
  logic [1:0]  e_sel = 0, e_addr = 0;
  logic [31:0] e_data = 0;
  logic [15:0] e_scan = 0;
  logic        e_done = 0;

  function automatic rec_t mk(input int s, input bit en, input bit clr, input bit we, input bit last);
    rec_t r;
    r.sel = 2'(s); r.en = en; r.clr = clr; r.we = we; r.last = last;
    return r;
  endfunction

  // A pass is the concatenation, per enabled RO in ascending order, of
  // settle + window + DRAIN + store + next cycles.
  task automatic build_pass(input logic [3:0] m, input int st, input int win);
    int top = -1;
    for (int i = 0; i < NUM_RO; i++) if (m[i]) top = i;
    for (int i = 0; i < NUM_RO; i++) begin
      if (m[i]) begin
        repeat ((st == 0) ? 1 : st)   q.push_back(mk(i, 0, 1, 0, 0));
        repeat ((win == 0) ? 1 : win) q.push_back(mk(i, 1, 0, 0, 0));
        repeat (DRAIN)                q.push_back(mk(i, 0, 0, 0, 0));
        q.push_back(mk(i, 0, 0, 1, 0));
        q.push_back(mk(i, 0, 0, 0, i == top));
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete(); cur_v = 0; sh_cont = 0;
        e_sel = 0; e_addr = 0; e_data = 0; e_scan = 0; e_done = 0;
      end else begin
        e_done = 0;
        if (cur_v) begin
          if (abort) begin
            q.delete(); cur_v = 0;
          end else begin
            if (cur.last && sh_cont) begin
              sh_cont = cfg_cont;
              build_pass(cfg_mask, int'(cfg_settle), int'(cfg_window));
            end
            if (q.size() > 0) begin cur = q.pop_front(); cur_v = 1; end
            else cur_v = 0;
          end
        end else if (start && !abort) begin
          sh_cont = cfg_cont;
          if (cfg_mask != 0) begin
            build_pass(cfg_mask, int'(cfg_settle), int'(cfg_window));
            cur = q.pop_front(); cur_v = 1;
          end else begin
            e_done = 1; e_scan++;
          end
        end
        if (cur_v) begin
          e_sel = cur.sel;
          if (cur.we) begin e_addr = cur.sel; e_data = cnt_value; end
          if (cur.last) begin e_done = 1; e_scan++; end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    check("busy",     busy,     cur_v);
    check("ro_en",    ro_en,    cur_v && cur.en);
    check("cnt_clr",  cnt_clr,  cur_v && cur.clr);
    check("res_we",   res_we,   cur_v && cur.we);
    check("done",     done,     e_done);
    check("ro_sel",   ro_sel,   e_sel);
    check("res_addr", res_addr, e_addr);
    check("res_data", res_data, e_data);
    check("scan_cnt", scan_cnt, e_scan);
  end

  initial begin
    forever begin
      @(negedge clk);
      cnt_value = $urandom;
    end
  end

  // ---------------- stimulus ----------------
  int we_k[$];
  int we_a[$];
  int done_k[$];
  int n_en, n_clr;

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; cfg_cont = 0;
    cfg_mask = 0; cfg_window = 0; cfg_settle = 0; cnt_value = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_scan", scan_cnt, 0);
    check("rst_ro_sel", ro_sel, 0);

    // Two ROs, settle 2, window 10: stores at 17 and 35, done 36, idle 37.
    cfg_mask = 4'b0101; cfg_settle = 2; cfg_window = 10;
    we_k.delete(); we_a.delete(); done_k.delete();
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 10);
      if (k == 20) cfg_mask = 4'b1111;
      if (res_we) begin we_k.push_back(k); we_a.push_back(int'(res_addr)); end
      if (done) done_k.push_back(k);
      if (k == 1)  check("b_busy1", busy, 1);
      if (k == 37) check("b_idle37", busy, 0);
    end
    check("b_we_n", we_k.size(), 2);
    check("b_we0_cyc", (we_k.size() > 0) ? we_k[0] : -1, 17);
    check("b_we0_addr", (we_a.size() > 0) ? we_a[0] : -1, 0);
    check("b_we1_cyc", (we_k.size() > 1) ? we_k[1] : -1, 35);
    check("b_we1_addr", (we_a.size() > 1) ? we_a[1] : -1, 2);
    check("b_done_cyc", (done_k.size() == 1) ? done_k[0] : -1, 36);
    check("b_scan", scan_cnt, 1);

    // Empty mask: done the next cycle, never busy, no writes.
    cfg_mask = 4'b0000;
    pulse_start();
    n_en = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      start = 0;
      if (res_we || busy) n_en++;
      if (k == 1) check("c_done1", done, 1);
      if (k == 2) check("c_done2", done, 0);
    end
    check("c_no_activity", n_en, 0);
    check("c_scan", scan_cnt, 2);

    // Continuous single RO: 18-cycle period; continuous cleared mid third pass.
    cfg_mask = 4'b1000; cfg_settle = 2; cfg_window = 10; cfg_cont = 1;
    done_k.delete();
    pulse_start();
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 40) cfg_cont = 0;
      if (done) done_k.push_back(k);
      if (k == 73) check("d_idle73", busy, 0);
    end
    check("d_done_n", done_k.size(), 4);
    for (int j = 0; j < done_k.size(); j++) check("d_done_cyc", done_k[j], 18 * (j + 1));
    check("d_scan", scan_cnt, 6);

    // Abort in GATE, then restart from the lowest set bit.
    cfg_mask = 4'b0110;
    pulse_start();
    n_en = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 0;
      abort = (k == 5);
      if (k == 5) check("e_en5", ro_en, 1);
      if (k == 6) begin check("e_en6", ro_en, 0); check("e_busy6", busy, 0); end
      if (k >= 6 && (res_we || done)) n_en++;
    end
    check("e_no_store_done", n_en, 0);
    check("e_scan", scan_cnt, 6);
    pulse_start();
    @(negedge clk);
    start = 0;
    check("e_restart_sel", ro_sel, 1);
    check("e_restart_clr", cnt_clr, 1);
    repeat (40) @(negedge clk);
    check("e_scan2", scan_cnt, 7);

    // Zero settle/window: one cycle each; mask change mid-pass has no effect.
    cfg_mask = 4'b0010; cfg_settle = 0; cfg_window = 0;
    we_k.delete(); we_a.delete(); done_k.delete();
    n_en = 0; n_clr = 0;
    pulse_start();
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 0;
      if (k == 2) begin cfg_mask = 4'b1111; cfg_settle = 3; end
      if (ro_en) n_en++;
      if (cnt_clr) n_clr++;
      if (res_we) begin we_k.push_back(k); we_a.push_back(int'(res_addr)); end
      if (done) done_k.push_back(k);
    end
    check("f_en_cycles", n_en, 1);
    check("f_clr_cycles", n_clr, 1);
    check("f_we_n", we_k.size(), 1);
    check("f_we_cyc", (we_k.size() > 0) ? we_k[0] : -1, 7);
    check("f_we_addr", (we_a.size() > 0) ? we_a[0] : -1, 1);
    check("f_done_cyc", (done_k.size() > 0) ? done_k[0] : -1, 8);

    // Async reset in HOLD (cycles 3..6 for settle 1, window 1).
    cfg_mask = 4'b0001; cfg_settle = 1; cfg_window = 1;
    pulse_start();
    repeat (4) begin @(negedge clk); start = 0; end
    check("g_busy_before", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("g_rst_busy", busy, 0);
    check("g_rst_outs", {ro_en, cnt_clr, res_we, done, ro_sel, res_addr}, 0);
    check("g_rst_data", res_data, 0);
    check("g_rst_scan", scan_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_mask   = 4'($urandom);
        cfg_settle = 8'($urandom_range(0, 3));
        cfg_window = 24'($urandom_range(0, 6));
        cfg_cont   = ($urandom_range(0, 3) == 0);
      end
    end
    @(negedge clk);
    start = 0; abort = 0; cfg_cont = 0;
    n_en = 0;
    while (busy && n_en < 300) begin
      @(negedge clk);
      n_en++;
    end
    check("h_drain_to_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
